// File: rtl/vga_pkg.sv
// Shared VGA constants: default object coordinate width, RGB332 field
// widths and the visible screen dimensions.
package vga_pkg;
    localparam int CW    = 12;
    localparam int R_W   = 3;
    localparam int G_W   = 3;
    localparam int B_W   = 2;
    localparam int RGB_W = R_W + G_W + B_W;
    localparam int H_ACT = 640;
    localparam int V_ACT = 480;
endpackage

// File: rtl/obj_hit.sv
// Strict axis-aligned rectangle test for one object. The pixel counters
// are zero-extended to the object coordinate width and compared unsigned.
// Open bounds mean a rectangle with x1 >= x2-1 (or y1 >= y2-1) never hits.
module obj_hit #(
    parameter int CW = 12
) (
    input  logic          en,
    input  logic [9:0]    x,
    input  logic [8:0]    y,
    input  logic [CW-1:0] x1,
    input  logic [CW-1:0] x2,
    input  logic [CW-1:0] y1,
    input  logic [CW-1:0] y2,
    output logic          hit
);
    logic [CW-1:0] x_ext;
    logic [CW-1:0] y_ext;

    assign x_ext = CW'(x);
    assign y_ext = CW'(y);

    // Pixel strictly inside the rectangle and object enabled
    always_comb begin
        hit = en && (x_ext > x1) && (x_ext < x2) && (y_ext > y1) && (y_ext < y2);
    end
endmodule

// File: rtl/sprite_mixer.sv
// Per-pixel object compositor. Stage 1 registers the per-object hit vector
// and the active flag; stage 2 resolves priority (lowest index wins) into a
// registered RGB332 pixel. Pixels with two or more overlapping objects are
// folded into a collision accumulator that is reported and cleared on each
// frame-end pulse.
module sprite_mixer #(
    parameter int         N_OBJ = 4,
    parameter int         CW    = 12,
    parameter logic [7:0] BG    = 8'h00
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pix_stb,
    input  logic              i_active,
    input  logic [9:0]        i_x,
    input  logic [8:0]        i_y,
    input  logic              i_frame_end,
    input  logic [N_OBJ-1:0]  i_en,
    input  logic [N_OBJ*CW-1:0] i_x1,
    input  logic [N_OBJ*CW-1:0] i_x2,
    input  logic [N_OBJ*CW-1:0] i_y1,
    input  logic [N_OBJ*CW-1:0] i_y2,
    input  logic [N_OBJ*8-1:0]  i_col,
    output logic [2:0]        o_r,
    output logic [2:0]        o_g,
    output logic [1:0]        o_b,
    output logic [N_OBJ-1:0]  o_coll,
    output logic              o_coll_vld
);
    import vga_pkg::*;

    logic [N_OBJ-1:0] hit_p0;
    logic [N_OBJ-1:0] hit_p1;
    logic             act_p1;
    logic [RGB_W-1:0] col_sel;
    logic [RGB_W-1:0] col_p2;
    logic [N_OBJ-1:0] acc;
    logic [N_OBJ-1:0] acc_nxt;
    logic             multi_p1;

    for (genvar k = 0; k < N_OBJ; k++) begin : g_hit
        obj_hit #(.CW(CW)) u_hit (
            .en (i_en[k]),
            .x  (i_x),
            .y  (i_y),
            .x1 (i_x1[k*CW +: CW]),
            .x2 (i_x2[k*CW +: CW]),
            .y1 (i_y1[k*CW +: CW]),
            .y2 (i_y2[k*CW +: CW]),
            .hit(hit_p0[k])
        );
    end

    // ---- stage 1: hit vector and active flag ----
    // Capture the hit vector and visibility on each pixel strobe
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hit_p1 <= '0;
            act_p1 <= 1'b0;
        end else if (i_pix_stb) begin
            hit_p1 <= hit_p0;
            act_p1 <= i_active;
        end
    end

    // ---- stage 2: priority select into the output colour register ----
    // Lowest set index wins; no hit gives BG; blanking forces black
    always_comb begin
        col_sel = BG;
        for (int k = N_OBJ - 1; k >= 0; k--) begin
            if (hit_p1[k]) col_sel = i_col[k*8 +: 8];
        end
        if (!act_p1) col_sel = '0;
    end

    // Register the resolved pixel; it drives the pins directly
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_p2 <= '0;
        end else if (i_pix_stb) begin
            col_p2 <= col_sel;
        end
    end

    assign o_r = col_p2[7:5];
    assign o_g = col_p2[4:2];
    assign o_b = col_p2[1:0];

    // Two or more bits set: clearing the lowest set bit leaves something
    assign multi_p1 = (hit_p1 & (hit_p1 - 1'b1)) != '0;

    // Accumulation from this clock is folded in so a frame-end pulse on the
    // same clock as an overlapping strobe still reports it
    always_comb begin
        acc_nxt = acc;
        if (i_pix_stb && act_p1 && multi_p1) acc_nxt = acc | hit_p1;
    end

    // Collision accumulator; report and clear on frame end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc        <= '0;
            o_coll     <= '0;
            o_coll_vld <= 1'b0;
        end else if (i_frame_end) begin
            acc        <= '0;
            o_coll     <= acc_nxt;
            o_coll_vld <= 1'b1;
        end else begin
            acc        <= acc_nxt;
            o_coll_vld <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sprite_mixer.sv
// Directed bench for sprite_mixer: single-object scan with latency,
// priority, blanking, collision reporting, frame-end coincidence and
// mid-frame reset.
module tb_sprite_mixer;
    localparam int         N  = 4;
    localparam int         CW = 12;
    localparam logic [7:0] BG_T = 8'hFF;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            pix_stb;
    logic            active;
    logic [9:0]      px;
    logic [8:0]      py;
    logic            frame_end;
    logic [N-1:0]    en;
    logic [N*CW-1:0] x1, x2, y1, y2;
    logic [N*8-1:0]  col;
    logic [2:0]      r, g;
    logic [1:0]      b;
    logic [N-1:0]    coll;
    logic            coll_vld;
    logic [7:0]      rgb;

    int n_chk  = 0;
    int n_fail = 0;

    assign rgb = {r, g, b};

    always #5 clk = ~clk;

    sprite_mixer #(.N_OBJ(N), .CW(CW), .BG(BG_T)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_pix_stb  (pix_stb),
        .i_active   (active),
        .i_x        (px),
        .i_y        (py),
        .i_frame_end(frame_end),
        .i_en       (en),
        .i_x1       (x1),
        .i_x2       (x2),
        .i_y1       (y1),
        .i_y2       (y2),
        .i_col      (col),
        .o_r        (r),
        .o_g        (g),
        .o_b        (b),
        .o_coll     (coll),
        .o_coll_vld (coll_vld)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_obj(input int k, input int ax1, input int ay1, input int ax2,
                           input int ay2, input logic [7:0] c);
        x1[k*CW +: CW] = CW'(ax1);
        y1[k*CW +: CW] = CW'(ay1);
        x2[k*CW +: CW] = CW'(ax2);
        y2[k*CW +: CW] = CW'(ay2);
        col[k*8 +: 8]  = c;
    endtask

    // One pixel: strobe for one clock (optionally with frame_end), then 3 idle clocks.
    // Called and returns at 1 time unit after a rising edge.
    task automatic step(input int x, input int y, input logic act, input logic fe);
        px        = 10'(x);
        py        = 9'(y);
        active    = act;
        pix_stb   = 1'b1;
        frame_end = fe;
        @(posedge clk); #1;
        pix_stb   = 1'b0;
        frame_end = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Frame-end pulse with no strobe; checks the one-clock report
    task automatic pulse_fe(input string tag, input logic [N-1:0] exp);
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
        chk({tag, "_coll"}, 32'(coll), 32'(exp));
        chk({tag, "_vld"}, 32'(coll_vld), 32'd1);
        @(posedge clk); #1;
        chk({tag, "_vld_drop"}, 32'(coll_vld), 32'd0);
    endtask

    function automatic logic [7:0] exp_single(input int x, input int y);
        return (x >= 101 && x <= 119 && y >= 101 && y <= 119) ? 8'hE0 : BG_T;
    endfunction

    // Pipelined scan: after each strobe the output shows the pixel presented one strobe earlier
    task automatic scan(input string tag, input int xa, input int xb, input int ya, input int yb);
        logic [7:0] prev;
        bit         have;
        have = 1'b0;
        prev = 8'h00;
        for (int y = ya; y <= yb; y++) begin
            for (int x = xa; x <= xb; x++) begin
                step(x, y, 1'b1, 1'b0);
                if (have) chk(tag, 32'(rgb), 32'(prev));
                prev = exp_single(x, y);
                have = 1'b1;
            end
        end
        step(0, 0, 1'b1, 1'b0);
        chk(tag, 32'(rgb), 32'(prev));
    endtask

    initial begin
        rst_n = 1'b0; pix_stb = 1'b0; active = 1'b0; px = '0; py = '0;
        frame_end = 1'b0; en = '0; x1 = '0; x2 = '0; y1 = '0; y2 = '0; col = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rgb", 32'(rgb), 32'h0);
        chk("rst_coll", 32'(coll), 32'h0);
        chk("rst_vld", 32'(coll_vld), 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single object, edges at 100 and 120 are exclusive
        set_obj(0, 100, 100, 120, 120, 8'hE0);
        en = 4'b0001;
        scan("single_row", 98, 122, 110, 110);
        scan("single_col", 110, 110, 98, 122);
        scan("single_corner", 99, 102, 99, 102);

        // Latency: red pixel not visible after one strobe, visible after two
        step(50, 50, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        step(110, 110, 1'b1, 1'b0);
        chk("lat_1stb", 32'(rgb), 32'(BG_T));
        step(0, 0, 1'b1, 1'b0);
        chk("lat_2stb", 32'(rgb), 32'hE0);

        // Priority: obj0 green over obj1 red
        set_obj(0, 100, 100, 120, 120, 8'h1C);
        set_obj(1, 100, 100, 120, 120, 8'hE0);
        en = 4'b0011;
        step(110, 110, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        chk("prio_green", 32'(rgb), 32'h1C);
        en = 4'b0010;
        step(110, 110, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        chk("prio_red", 32'(rgb), 32'hE0);

        // Blanking inside an object and on background
        step(110, 110, 1'b0, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        chk("blank_obj", 32'(rgb), 32'h00);
        step(5, 5, 1'b0, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        chk("blank_bg", 32'(rgb), 32'h00);

        // Priority overlap above accumulated objects 0 and 1
        pulse_fe("fe_prio", 4'b0011);

        // Collision: obj1 and obj3 share only (209,209); obj2 stands alone
        set_obj(1, 200, 200, 210, 210, 8'h03);
        set_obj(2, 300, 300, 310, 310, 8'h1C);
        set_obj(3, 208, 208, 220, 220, 8'hE0);
        en = 4'b1110;
        step(205, 205, 1'b1, 1'b0);
        step(209, 209, 1'b1, 1'b0);
        step(305, 305, 1'b1, 1'b0);
        chk("coll_pix_prio", 32'(rgb), 32'h03);
        step(215, 215, 1'b1, 1'b0);
        step(210, 210, 1'b1, 1'b0);
        chk("coll_obj3", 32'(rgb), 32'hE0);
        pulse_fe("fe_coll", 4'b1010);
        step(205, 205, 1'b1, 1'b0);
        step(305, 305, 1'b1, 1'b0);
        step(215, 215, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        pulse_fe("fe_clean", 4'b0000);

        // Overlap reaches the accumulator on the same clock as frame end
        step(209, 209, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b1);
        chk("sim_coll", 32'(coll), 32'hA);
        repeat (2) step(0, 0, 1'b1, 1'b0);
        pulse_fe("fe_after_sim", 4'b0000);

        // Mid-frame reset
        step(209, 209, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        pulse_fe("fe_pre_rst", 4'b1010);
        step(209, 209, 1'b1, 1'b0);
        step(215, 215, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        chk("pre_rst_rgb", 32'(rgb), 32'hE0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_rgb", 32'(rgb), 32'h0);
        chk("rst_mid_coll", 32'(coll), 32'h0);
        chk("rst_mid_vld", 32'(coll_vld), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(205, 205, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b0);
        pulse_fe("fe_post_rst", 4'b0000);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/sprite_mixer.md
# sprite_mixer

Parametrised per-pixel object compositor for the 640x480 VGA path. Takes up to N_OBJ axis-aligned rectangles (player ship, bullets, light streaks, future enemies), resolves them by fixed priority into one registered RGB332 pixel, and latches a per-frame object-overlap (collision) vector for game logic. Sits between the VGA timing generator and the VGA pins. It replaces hand-written per-sprite hit tests and OR'd colour bits in the top level.

## Interface
- N_OBJ, 4, number of objects; index 0 has highest priority
- CW, 12, object coordinate width (bits)
- BG, 8'h00, background RGB332 colour in the active area
- i_clk  in  1  system clock (100 MHz)
- i_rst_n  in  1  asynchronous, active-low reset
- i_pix_stb  in  1  pixel-enable strobe (1-in-4 clocks); the pipeline advances only when high
- i_active  in  1  current pixel is in the visible area
- i_x  in  10  pixel x (0..639)
- i_y  in  9  pixel y (0..479)
- i_frame_end  in  1  single-clock pulse at the end of the drawn frame (animate pulse)
- i_en  in  N_OBJ  per-object enable
- i_x1, i_x2, i_y1, i_y2  in  N_OBJ*CW each  flattened bounds; object k occupies bits [k*CW +: CW]
- i_col  in  N_OBJ*8  flattened RGB332 colour per object ({R[2:0],G[2:0],B[1:0]})
- o_r  out  3  red
- o_g  out  3  green
- o_b  out  2  blue
- o_coll  out  N_OBJ  bit k set: object k overlapped another enabled object during the last frame
- o_coll_vld  out  1  one-clock pulse when o_coll is updated

## Operation
- Hit test for object k: i_en[k] & (x > x1) & (x < x2) & (y > y1) & (y < y2). Inequalities are strict; i_x and i_y are zero-extended to CW bits; unsigned compare. x1 >= x2-1 or y1 >= y2-1 gives no hit.
- Stage 1 (on i_pix_stb): register the hit vector h[N_OBJ-1:0] and i_active.
- Stage 2 (on i_pix_stb): priority select. The lowest-index set bit of h chooses the colour. If h is zero, the colour is BG. If registered active is low, the colour is 8'h00.
- The colour register drives {o_r,o_g,o_b} directly; there is no combinational path from the inputs.
- Collision accumulator acc[N_OBJ-1:0]: on a strobe where stage-1 active is high and popcount(h) >= 2, update acc |= h.
- On i_frame_end:
  - o_coll <= acc, including any accumulation occurring in the same clock.
  - acc <= 0.
  - o_coll_vld <= 1 for exactly one clock.
- i_frame_end does not need to coincide with i_pix_stb.
- Bounds and colours are sampled every strobe. Changing them mid-frame takes effect on the next strobe; there is no shadowing.
- An object disabled mid-frame keeps acc bits already set until frame end.

## Timing
- Latency: colour for pixel (x,y) presented at stage 1 appears on the outputs 2 strobes later, i.e. 2 pixels. The timing generator delays hs/vs by 2 strobes to match.
- Between strobes, all registers hold.
- Reset (async assert, sync deassert via the external synchroniser):
  - o_r/o_g/o_b = 0.
  - o_coll = 0, o_coll_vld = 0.
  - acc = 0, pipeline h = 0, active = 0.
- Reset asserted mid-frame clears acc. The next frame_end reports only post-reset overlaps.
- Back-to-back i_frame_end pulses: the second reports 0 unless new overlaps occur in between.

## Structure
- Package vga_pkg: CW, RGB332 field widths (3/3/2), screen constants H_ACT=640, V_ACT=480.
- Sub-module obj_hit (combinational strict rectangle test, one per object via generate). The priority encoder and accumulator are inline.
- Target size: 150–250 lines of RTL.

## Test plan
- **Single object:** obj0 = (100,100)-(120,120), colour 8'hE0, enabled; scan the frame.
  - Red (7,0,0) appears exactly at x,y in 101..119, 2 strobes after presentation.
  - Pixels at x=100 and x=120 show BG.
- **Priority:** obj0 colour 8'h1C and obj1 colour 8'hE0 over the same rectangle.
  - Output is green (0,7,0).
  - With obj0 disabled, output is red.
- **Blanking:** i_active=0 inside an object rectangle.
  - Output is 0 two strobes later, regardless of BG=8'hFF.
- **Collision:** obj1 and obj3 overlap at one pixel; obj2 overlaps nothing; assert i_frame_end.
  - o_coll=4'b1010 with a one-clock o_coll_vld.
  - Next frame with no overlap gives o_coll=0.
- **Simultaneous event:** first overlapping pixel strobe coincides with i_frame_end.
  - That overlap is included in o_coll.
  - acc is 0 afterwards.
- **Reset mid-frame:** overlap accumulated, then i_rst_n low for 3 clocks, then release.
  - All outputs 0 immediately on assertion.
  - Next i_frame_end reports 0 when there are no further overlaps.
